// File: rtl/csla_pkg.sv
// Shared widths and state encoding for the CSLA stream accumulator.
// Defines the adder data width, default counter widths and FSM states.
package csla_pkg;
    localparam int DATA_W      = 32;
    localparam int CARRY_W_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;
endpackage

// File: rtl/main.sv
// 32-bit carry-select adder: 4-bit ripple blocks, carry-in-1 result from a binary-to-excess-1 step.
// Latency: combinational.
// Backpressure: none, pure datapath.
module main
    import csla_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);
    localparam int NBLK = DATA_W / 4;

    logic [NBLK:1] c;

    assign {c[1], sum[3:0]} = {1'b0, a[3:0]} + {1'b0, b[3:0]};

    for (genvar k = 1; k < NBLK; k++) begin : g_blk
        logic [4:0] r0;
        logic [4:0] r1;
        assign r0 = {1'b0, a[4*k+3:4*k]} + {1'b0, b[4*k+3:4*k]};
        // r0 never exceeds 5'h1e, so the excess-1 form cannot overflow its 5 bits
        assign r1 = r0 + 5'd1;
        assign {c[k+1], sum[4*k+3:4*k]} = c[k] ? r1 : r0;
    end

    assign cout = c[NBLK];
endmodule

// File: rtl/csla_stream_accum.sv
// Packet accumulator around the CSLA adder: sums words, counts adder carries and words.
// Latency: result valid 1 cycle after the last word is accepted.
// Backpressure: in_ready drops while a result is held and out_ready is low.
module csla_stream_accum
    import csla_pkg::*;
#(
    parameter int CARRY_W = CARRY_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sum,
    output logic [CARRY_W-1:0] out_carries,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_sat
);
    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [CARRY_W-1:0] carry_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic               sat;

    logic               hold;
    logic               accept;
    logic [DATA_W-1:0]  base;
    logic [CARRY_W-1:0] base_cc;
    logic [CNT_W-1:0]   base_wc;
    logic               base_sat;
    logic [DATA_W-1:0]  add_sum;
    logic               add_cout;
    logic [CARRY_W:0]   carry_inc;
    logic [CNT_W:0]     word_inc;

    assign hold     = (state == ST_HOLD);
    assign in_ready = !hold || out_ready;
    assign accept   = in_valid && in_ready;

    // An accept while holding consumes the result, so the new word opens a fresh packet.
    assign base     = hold ? '0 : acc;
    assign base_cc  = hold ? '0 : carry_cnt;
    assign base_wc  = hold ? '0 : word_cnt;
    assign base_sat = hold ? 1'b0 : sat;

    main u_add (
        .a    (base),
        .b    (in_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign carry_inc = {1'b0, base_cc} + {{CARRY_W{1'b0}}, add_cout};
    assign word_inc  = {1'b0, base_wc} + {{CNT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            carry_cnt <= '0;
            word_cnt  <= '0;
            sat       <= 1'b0;
        end else if (accept) begin
            acc       <= add_sum;
            carry_cnt <= carry_inc[CARRY_W] ? '1 : carry_inc[CARRY_W-1:0];
            word_cnt  <= word_inc[CNT_W] ? '1 : word_inc[CNT_W-1:0];
            sat       <= base_sat || carry_inc[CARRY_W] || word_inc[CNT_W];
            state     <= in_last ? ST_HOLD : ST_ACCUM;
        end else if (hold && out_ready) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            carry_cnt <= '0;
            word_cnt  <= '0;
            sat       <= 1'b0;
        end
    end

    assign out_valid   = hold;
    assign out_sum     = acc;
    assign out_carries = carry_cnt;
    assign out_count   = word_cnt;
    assign out_sat     = sat;
endmodule

// File: tb/tb_csla_stream_accum.sv
// Directed bench for csla_stream_accum with a 2-bit word counter to reach saturation.
module tb_csla_stream_accum;
    localparam int CW = 8;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_sum;
    logic [CW-1:0] out_carries;
    logic [NW-1:0] out_count;
    logic          out_sat;

    int n_chk  = 0;
    int n_fail = 0;

    csla_stream_accum #(.CARRY_W(CW), .CNT_W(NW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carries (out_carries),
        .out_count   (out_count),
        .out_sat     (out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   data;
        logic          last;
        logic          vld;
        logic [31:0]   sum;
        logic [CW-1:0] car;
        logic [NW-1:0] cnt;
        logic          sat;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] s, input logic [CW-1:0] c,
                           input logic [NW-1:0] n, input logic sat);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, out_sum, s);
        chk({tag, ".carries"}, 32'(out_carries), 32'(c));
        chk({tag, ".count"}, 32'(out_count), 32'(n));
        chk({tag, ".sat"}, 32'(out_sat), 32'(sat));
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'h56745675, 1'b0, 1'b0, 32'h0, 8'd0, 2'd0, 1'b0};
        tbl[1] = '{32'h54546576, 1'b1, 1'b1, 32'hAAC8BBEB, 8'd0, 2'd2, 1'b0};
        tbl[2] = '{32'hAB674594, 1'b0, 1'b0, 32'h0, 8'd0, 2'd0, 1'b0};
        tbl[3] = '{32'hAC784387, 1'b0, 1'b0, 32'h0, 8'd0, 2'd0, 1'b0};
        tbl[4] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h57DF891A, 8'd2, 2'd3, 1'b0};
        tbl[5] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678, 8'd0, 2'd1, 1'b0};
        tbl[6] = '{32'h80000000, 1'b1, 1'b1, 32'h80000000, 8'd0, 2'd1, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.sum", out_sum, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'd1);
            send(tbl[i].data, tbl[i].last);
            chk($sformatf("tbl%0d.valid", i), 32'(out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk_res($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].car, tbl[i].cnt, tbl[i].sat);
                step();
                chk($sformatf("tbl%0d.drain", i), 32'(out_valid), 32'd0);
            end
        end

        // Backpressure: result held while out_ready is low; stray input is refused.
        out_ready = 1'b0;
        send(32'hFFFFFFFF, 1'b0);
        send(32'h00000001, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h99;
            in_last  = 1'b1;
            #1;
            chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
            chk_res($sformatf("bp%0d", k), 32'h0, 8'd1, 2'd2, 1'b0);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp.release", 32'(out_valid), 32'd0);
        send(32'h3, 1'b1);
        chk_res("bp.next", 32'h3, 8'd0, 2'd1, 1'b0);

        // Back-to-back: consume and start a new single-word packet in one cycle.
        in_valid = 1'b1;
        in_data  = 32'h5;
        in_last  = 1'b1;
        #1;
        chk("b2b.in_ready", 32'(in_ready), 32'd1);
        chk("b2b.valid_same", 32'(out_valid), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_res("b2b", 32'h5, 8'd0, 2'd1, 1'b0);
        send(32'h20, 1'b0);
        chk("b2b2.valid", 32'(out_valid), 32'd0);
        send(32'h1, 1'b1);
        chk_res("b2b2", 32'h21, 8'd0, 2'd2, 1'b0);
        step();

        // Word counter saturation at 3.
        send(32'h1, 1'b0);
        send(32'h1, 1'b0);
        send(32'h1, 1'b0);
        chk("sat3.sat", 32'(out_sat), 32'd0);
        send(32'h1, 1'b1);
        chk_res("sat", 32'h4, 8'd0, 2'd3, 1'b1);
        step();

        // Reset mid-packet, then a fresh single-word packet.
        send(32'h1, 1'b0);
        send(32'h1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst.sum", out_sum, 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        step();
        send(32'h7, 1'b1);
        chk_res("midrst.pkt", 32'h7, 8'd0, 2'd1, 1'b0);

        // Async reset while holding a result, no clock edge needed.
        out_ready = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("hrst.valid", 32'(out_valid), 32'd0);
        chk("hrst.in_ready", 32'(in_ready), 32'd1);
        chk("hrst.sum", out_sum, 32'd0);
        chk("hrst.count", 32'(out_count), 32'd0);
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
